// File: rtl/div32u_pkg.sv
// Shared definitions for the sequential 2W/W unsigned divider.
// Build option: define DIV32U_TRUNC_EN for the truncated variant, which skips
// the lowest TRUNC_BITS dividend bits. Without it the division is exact.
package div32u_pkg;

  localparam int W_DEF      = 16;
  localparam int TRUNC_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Number of restoring steps CALC performs for a divisor width w.
  function automatic int steps_for(input int w);
`ifdef DIV32U_TRUNC_EN
    return w - TRUNC_BITS;
`else
    return w;
`endif
  endfunction

  localparam int DIV_STEPS = steps_for(W_DEF);

endpackage

// File: rtl/div32u_seq_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  // rem_i < div_i on entry, so the shifted value is below 2*div_i and the
  // difference, when taken, always fits in W bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted[W-1:0] - div_i;
    q_o     = (shifted >= {1'b0, div_i});
    rem_o   = q_o ? diff : shifted[W-1:0];
  end

endmodule

// File: rtl/div32u_seq.sv
// Sequential unsigned divider: 2W-bit dividend by W-bit divisor, one
// restoring step per cycle, with divide-by-zero and quotient-overflow
// shortcuts that finish immediately.
// Build option: DIV32U_TRUNC_EN selects the truncated variant (W-4 steps on
// a[2W-1:4], quotient low bits forced to zero).
//
// Handshakes: an operand pair is taken on a rising edge where
// in_valid && in_ready; a result is consumed on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE and out_valid only in
// DONE, so capture and result handoff can never share an edge.
module div32u_seq
  import div32u_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           dbz,
  output logic           ovf,
  output logic [1:0]     dbg_state
);

  localparam int STEPS = steps_for(W);
  localparam int CW    = $clog2(W + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  lo_q, lo_d;   // remaining dividend bits, quotient shifts in
  logic [W-1:0]  div_q, div_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  step_rem;
  logic          step_qbit;
  logic          ovf_in;

  div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .bit_i (lo_q[W-1]),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_qbit)
  );

  assign ovf_in    = (a[2*W-1:W] >= b) && (b != '0);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign q         = lo_q;
  assign r         = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

  // Next-state and datapath selection for capture, stepping and handoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          div_d = b;
          cnt_d = '0;
          if (b == '0) begin
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            lo_d    = '1;
            rem_d   = a[W-1:0];
            state_d = ST_DONE;
          end else if (ovf_in) begin
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            lo_d    = '1;
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            rem_d   = a[2*W-1:W];
            lo_d    = a[W-1:0];
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        lo_d  = {lo_q[W-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = ST_DONE;
`ifdef DIV32U_TRUNC_EN
          // Drop the unused dividend bits still sitting above the quotient
          // and align the quotient so its low TRUNC_BITS read as zero.
          lo_d = {lo_q[W-TRUNC_BITS-2:0], step_qbit, {TRUNC_BITS{1'b0}}};
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      div_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/div32u_seq.md
DIV32U_SEQ -- requirements
Module: div32u_seq

Interface
REQ-001 Parameter: W, 16, divisor/quotient/remainder width; the dividend is 2*W bits wide.
REQ-002 Port: clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  the operand pair is valid.
REQ-005 Port: in_ready  output  1  the block can accept operands.
REQ-006 Port: a  input  2W  unsigned dividend.
REQ-007 Port: b  input  W  unsigned divisor.
REQ-008 Port: out_valid  output  1  the result is valid.
REQ-009 Port: out_ready  input  1  the consumer accepts the result.
REQ-010 Port: q  output  W  quotient.
REQ-011 Port: r  output  W  remainder.
REQ-012 Port: dbz  output  1  divide-by-zero flag.
REQ-013 Port: ovf  output  1  quotient-overflow flag, set when a[2W-1:W] >= b and b != 0.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and operands SHALL be captured only on a cycle where in_valid && in_ready.
REQ-016 The next state after a capture SHALL be DONE when b==0 or ovf, and CALC otherwise.
REQ-017 When b==0, the result SHALL be q=all-ones, r=a[W-1:0], dbz=1, ovf=0.
REQ-018 On overflow, the result SHALL be q=all-ones, r=0, ovf=1, dbz=0.
REQ-019 CALC SHALL perform one restoring shift/compare/subtract step per cycle, MSB first, on a (W+1)-bit partial remainder.
REQ-020 CALC SHALL run for W steps in the exact build, then move to DONE.
REQ-021 For a normal operation, out_valid SHALL rise exactly W+1 cycles after the capture edge (17 for W=16).
REQ-022 For dbz or ovf, out_valid SHALL rise 1 cycle after the capture edge.
REQ-023 In DONE, out_valid=1, and q/r/dbz/ovf SHALL remain stable until out_valid && out_ready.
REQ-024 On the output handshake the FSM SHALL return to IDLE, with out_valid=0 on the next cycle.
REQ-025 New operands SHALL NOT be captured on the same edge as the output handshake (no overlap); the earliest next capture is the following cycle.
REQ-026 Input changes while in_ready=0 SHALL be ignored.
REQ-027 The exact result SHALL satisfy a == q*b + r with r < b.

Reset
REQ-028 rst SHALL force: state IDLE, out_valid=0, q=0, r=0, dbz=0, ovf=0, and clear the internal counter and remainder.
REQ-029 When not in reset, in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-030 rst asserted during CALC or DONE SHALL abandon the operation without emitting a result.

Configuration
REQ-031 The macro DIV32U_TRUNC_EN SHALL select between the exact and truncated builds.
REQ-032 Without DIV32U_TRUNC_EN (the default), the block SHALL be exact per REQ-020 and REQ-027.
REQ-033 With DIV32U_TRUNC_EN, CALC SHALL run W-4 steps on a[2W-1:4] only.
REQ-034 With DIV32U_TRUNC_EN, q[3:0] SHALL be 0 and r SHALL be the partial remainder after the final step.
REQ-035 With DIV32U_TRUNC_EN, normal-operation latency SHALL be W-3 cycles (13 for W=16).
REQ-036 The dbz and ovf paths SHALL be unchanged in both builds.

Structure
REQ-037 Package div32u_pkg SHALL hold: the W default, the state enum type, the TRUNC_BITS=4 constant, and the step-count constant.
REQ-038 The single sub-module div_step SHALL be combinational and compute one restoring step: inputs partial remainder, next dividend bit and divisor; outputs new partial remainder and quotient bit.

Verification
REQ-039 Scenario, exact build: a=100000, b=7 -> q=14285, r=5, dbz=0, ovf=0, out_valid 17 cycles after capture.
REQ-040 Scenario, truncated build: a=100000, b=7 -> q=14272, r=6, out_valid 13 cycles after capture.
REQ-041 Scenario, dbz and ovf: a=0x1234, b=0 -> q=0xFFFF, r=0x1234, dbz=1, latency 1; a=0x00070000, b=7 -> q=0xFFFF, r=0, ovf=1, latency 1.
REQ-042 Scenario, boundary: a=0xFFFE0001, b=0xFFFF -> q=0xFFFF, r=0, ovf=0.
REQ-043 Scenario, backpressure: hold out_ready=0 for 5 cycles in DONE -> q/r stable, out_valid=1, in_ready=0; a back-to-back second operation is captured the cycle after the handshake.
REQ-044 Scenario, reset mid-operation: rst pulsed on CALC cycle 8 -> next cycle out_valid=0, in_ready=1, q=r=0, and no result is emitted.
